// File: rtl/maria_pkg.sv
// Shared types and timing constant sets for the Maria display-list DMA blocks.
package maria_pkg;

    localparam int unsigned BEAM_W = 9;

    typedef logic [BEAM_W-1:0] beam_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ZP_BUSY = 2'd1,
        ST_ARMED   = 2'd2,
        ST_DP_BUSY = 2'd3
    } dma_sched_state_t;

    // NTSC beam timing
    localparam int unsigned NTSC_LINE_CYCLES = 454;
    localparam int unsigned NTSC_FRAME_LINES = 263;
    localparam int unsigned NTSC_FIRST_LINE  = 16;
    localparam int unsigned NTSC_LAST_LINE   = 258;

    // PAL beam timing
    localparam int unsigned PAL_LINE_CYCLES  = 454;
    localparam int unsigned PAL_FRAME_LINES  = 313;
    localparam int unsigned PAL_FIRST_LINE   = 16;
    localparam int unsigned PAL_LAST_LINE    = 308;

endpackage

// File: rtl/maria_dma_sched_if.sv
// Start/kill/done handshake between the line scheduler and the DMA controller.
interface maria_dma_sched_if;

    logic zp_dma_start;
    logic dp_dma_start;
    logic dp_dma_kill;
    logic zp_dma_done;
    logic dp_dma_done;
    logic dp_dma_done_dli;

    modport master (
        output zp_dma_start,
        output dp_dma_start,
        output dp_dma_kill,
        input  zp_dma_done,
        input  dp_dma_done,
        input  dp_dma_done_dli
    );

    modport slave (
        input  zp_dma_start,
        input  dp_dma_start,
        input  dp_dma_kill,
        output zp_dma_done,
        output dp_dma_done,
        output dp_dma_done_dli
    );

endinterface

// File: rtl/maria_beam_counter.sv
// Horizontal/vertical beam counters with registered vblank and last_line flags.
// The look-ahead counts let the scheduler register pulses that line up with
// the count values they refer to.
module maria_beam_counter
    import maria_pkg::*;
#(
    parameter int unsigned LINE_CYCLES = NTSC_LINE_CYCLES,
    parameter int unsigned FRAME_LINES = NTSC_FRAME_LINES,
    parameter int unsigned FIRST_LINE  = NTSC_FIRST_LINE,
    parameter int unsigned LAST_LINE   = NTSC_LAST_LINE
) (
    input  logic  sysclk,
    input  logic  reset,
    output beam_t hcount,
    output beam_t vcount,
    output logic  vblank,
    output logic  last_line,
    output beam_t hcount_nxt_c,
    output beam_t vcount_nxt_c,
    output logic  frame_wrap_c
);

    logic line_end;

    // Next beam position and wrap detection
    always_comb begin
        line_end     = (hcount == beam_t'(LINE_CYCLES - 1));
        frame_wrap_c = line_end && (vcount == beam_t'(FRAME_LINES - 1));
        hcount_nxt_c = line_end ? '0 : hcount + beam_t'(1);
        vcount_nxt_c = vcount;
        if (frame_wrap_c) begin
            vcount_nxt_c = '0;
        end else if (line_end) begin
            vcount_nxt_c = vcount + beam_t'(1);
        end
    end

    // Counters and line flags advance together so they always agree
    always_ff @(posedge sysclk) begin
        if (reset) begin
            hcount    <= '0;
            vcount    <= '0;
            vblank    <= 1'b1;
            last_line <= 1'b0;
        end else begin
            hcount    <= hcount_nxt_c;
            vcount    <= vcount_nxt_c;
            vblank    <= (vcount_nxt_c < beam_t'(FIRST_LINE)) ||
                         (vcount_nxt_c > beam_t'(LAST_LINE));
            last_line <= (vcount_nxt_c == beam_t'(LAST_LINE));
        end
    end

endmodule

// File: rtl/maria_dma_sched.sv
// Maria display-list DMA scheduler: issues zone-header and per-line fetches,
// kills overrunning line fetches, and drives CPU halt and the DLI NMI.
module maria_dma_sched
    import maria_pkg::*;
#(
    parameter int unsigned LINE_CYCLES = NTSC_LINE_CYCLES,
    parameter int unsigned FRAME_LINES = NTSC_FRAME_LINES,
    parameter int unsigned FIRST_LINE  = NTSC_FIRST_LINE,
    parameter int unsigned LAST_LINE   = NTSC_LAST_LINE,
    parameter int unsigned ZP_CYCLE    = 16,
    parameter int unsigned DP_START    = 28,
    parameter int unsigned DP_KILL     = 428,
    parameter int unsigned NMI_CYCLES  = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              dma_en,
    maria_dma_sched_if.master dma,
    output logic              last_line,
    output logic              halt,
    output logic              nmi,
    output beam_t             hcount,
    output beam_t             vcount,
    output logic              vblank
);

    localparam int unsigned NMI_W = $clog2(NMI_CYCLES + 1);

    beam_t            hcount_nxt_c;
    beam_t            vcount_nxt_c;
    logic             frame_wrap_c;
    dma_sched_state_t state;
    dma_sched_state_t state_nxt;
    logic             zp_hit;
    logic             dp_hit;
    logic             kill_hit;
    logic             zp_start_d;
    logic             dp_start_d;
    logic             kill_d;
    logic             halt_d;
    logic             nmi_d;
    logic             kill_sent;
    logic             kill_sent_d;
    logic [NMI_W-1:0] nmi_cnt;
    logic [NMI_W-1:0] nmi_cnt_d;
    logic             zp_start_q;
    logic             dp_start_q;
    logic             kill_q;

    maria_beam_counter #(
        .LINE_CYCLES (LINE_CYCLES),
        .FRAME_LINES (FRAME_LINES),
        .FIRST_LINE  (FIRST_LINE),
        .LAST_LINE   (LAST_LINE)
    ) u_beam (
        .sysclk       (sysclk),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .vblank       (vblank),
        .last_line    (last_line),
        .hcount_nxt_c (hcount_nxt_c),
        .vcount_nxt_c (vcount_nxt_c),
        .frame_wrap_c (frame_wrap_c)
    );

    // Trigger points compared against the upcoming beam position
    always_comb begin
        zp_hit   = dma_en && (vcount_nxt_c == beam_t'(FIRST_LINE - 1)) &&
                   (hcount_nxt_c == beam_t'(ZP_CYCLE));
        dp_hit   = dma_en && (vcount_nxt_c >= beam_t'(FIRST_LINE)) &&
                   (vcount_nxt_c <= beam_t'(LAST_LINE)) &&
                   (hcount_nxt_c == beam_t'(DP_START));
        kill_hit = (hcount_nxt_c == beam_t'(DP_KILL));
    end

    // State register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a done pulse outside a transfer is ignored here
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (zp_hit)          state_nxt = ST_ZP_BUSY;
            ST_ZP_BUSY: if (dma.zp_dma_done) state_nxt = ST_ARMED;
            ST_ARMED:   if (dp_hit)          state_nxt = ST_DP_BUSY;
            ST_DP_BUSY: if (dma.dp_dma_done) begin
                state_nxt = (vcount == beam_t'(LAST_LINE)) ? ST_IDLE : ST_ARMED;
            end
            default:    state_nxt = ST_IDLE;
        endcase
        if (frame_wrap_c && (state_nxt != ST_ZP_BUSY) && (state_nxt != ST_DP_BUSY)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Output decode; a done on the kill edge completes the line and suppresses the kill
    always_comb begin
        zp_start_d  = (state == ST_IDLE)  && (state_nxt == ST_ZP_BUSY);
        dp_start_d  = (state == ST_ARMED) && (state_nxt == ST_DP_BUSY);
        kill_d      = (state == ST_DP_BUSY) && (state_nxt == ST_DP_BUSY) &&
                      kill_hit && !kill_sent;
        halt_d      = (state_nxt == ST_ZP_BUSY) || (state_nxt == ST_DP_BUSY);
        kill_sent_d = kill_sent;
        if (dp_start_d) begin
            kill_sent_d = 1'b0;
        end else if (kill_d) begin
            kill_sent_d = 1'b1;
        end
        nmi_cnt_d = nmi_cnt;
        if ((dma.zp_dma_done || dma.dp_dma_done) && dma.dp_dma_done_dli) begin
            nmi_cnt_d = NMI_W'(NMI_CYCLES);
        end else if (nmi_cnt != '0) begin
            nmi_cnt_d = nmi_cnt - NMI_W'(1);
        end
        nmi_d = (nmi_cnt_d != '0);
    end

    // Registered pulses, halt and DLI counter
    always_ff @(posedge sysclk) begin
        if (reset) begin
            zp_start_q <= 1'b0;
            dp_start_q <= 1'b0;
            kill_q     <= 1'b0;
            kill_sent  <= 1'b0;
            halt       <= 1'b0;
            nmi_cnt    <= '0;
            nmi        <= 1'b0;
        end else begin
            zp_start_q <= zp_start_d;
            dp_start_q <= dp_start_d;
            kill_q     <= kill_d;
            kill_sent  <= kill_sent_d;
            halt       <= halt_d;
            nmi_cnt    <= nmi_cnt_d;
            nmi        <= nmi_d;
        end
    end

    assign dma.zp_dma_start = zp_start_q;
    assign dma.dp_dma_start = dp_start_q;
    assign dma.dp_dma_kill  = kill_q;

endmodule

// File: tb/tb_maria_dma_sched.sv
// Bench for maria_dma_sched using a shortened frame so several frames fit in
// a short run. A cycle-level reference derives the beam position from the
// number of clocks since reset and tracks fetch progress with plain flags.
module tb_maria_dma_sched;
    import maria_pkg::*;

    localparam int TL     = 64;
    localparam int TF     = 40;
    localparam int TFIRST = 4;
    localparam int TLAST  = 34;
    localparam int TZP    = 16;
    localparam int TDP    = 28;
    localparam int TKILL  = 56;
    localparam int TNMI   = 8;

    logic  sysclk = 1'b0;
    logic  reset  = 1'b1;
    logic  dma_en = 1'b1;
    logic  last_line, halt, nmi, vblank;
    beam_t hcount, vcount;

    maria_dma_sched_if dma_if ();

    maria_dma_sched #(
        .LINE_CYCLES (TL),
        .FRAME_LINES (TF),
        .FIRST_LINE  (TFIRST),
        .LAST_LINE   (TLAST),
        .ZP_CYCLE    (TZP),
        .DP_START    (TDP),
        .DP_KILL     (TKILL),
        .NMI_CYCLES  (TNMI)
    ) u_dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .dma_en    (dma_en),
        .dma       (dma_if),
        .last_line (last_line),
        .halt      (halt),
        .nmi       (nmi),
        .hcount    (hcount),
        .vcount    (vcount),
        .vblank    (vblank)
    );

    always #5 sysclk = ~sysclk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model
    int k = 0;
    bit m_zone, m_line, m_armed, m_kill_sent;
    int m_nmi = 0;
    bit e_zp, e_dp, e_kill;

    // DMA controller stand-in
    int resp_cnt  = -1;
    int resp_kind = 0;
    int lat       = 1;
    bit resp_dli  = 0;
    bit hold_dp   = 0;
    bit rnd_mode  = 0;
    bit man_zp    = 0;
    bit man_dp    = 0;
    bit man_dli   = 0;
    int cnt_zp    = 0;
    int cnt_dp    = 0;

    typedef struct {
        int         v;
        int         h;
        logic       en;
        logic [4:0] exp;   // {zp_start, dp_start, halt, vblank, last_line}
    } vec_t;
    vec_t tbl [10];

    function automatic int cur_h();
        return k % TL;
    endfunction

    function automatic int cur_v();
        return (k / TL) % TF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (v=%0d h=%0d)", name, act, exp, cur_v(), cur_h());
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare all outputs
    task automatic step();
        bit zd, dd, dl, en;
        int v0, nh, nv;
        bit was_idle, was_armed;
        logic [31:0] act, exp;
        zd = man_zp; dd = man_dp; dl = man_dli;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                if (resp_kind == 1) zd = 1'b1; else dd = 1'b1;
                dl = dl | resp_dli;
                resp_cnt = -1;
            end
        end
        dma_if.zp_dma_done     = zd;
        dma_if.dp_dma_done     = dd;
        dma_if.dp_dma_done_dli = dl;
        man_zp = 0; man_dp = 0; man_dli = 0;
        v0 = cur_v();
        en = dma_en;
        @(posedge sysclk);
        if (reset) begin
            k = 0;
            m_zone = 0; m_line = 0; m_armed = 0; m_kill_sent = 0;
            m_nmi = 0; e_zp = 0; e_dp = 0; e_kill = 0;
            resp_cnt = -1;
        end else begin
            k++;
            nh = cur_h();
            nv = cur_v();
            was_idle  = !m_zone && !m_line && !m_armed;
            was_armed = m_armed;
            e_zp = 0; e_dp = 0; e_kill = 0;
            if (m_line) begin
                if (dd) begin
                    m_line  = 0;
                    m_armed = (v0 != TLAST);
                end else if (nh == TKILL && !m_kill_sent) begin
                    e_kill = 1; m_kill_sent = 1;
                end
            end
            if (m_zone && zd) begin
                m_zone = 0; m_armed = 1;
            end
            if (was_idle && en && nv == TFIRST - 1 && nh == TZP) begin
                e_zp = 1; m_zone = 1;
            end
            if (was_armed && en && nv >= TFIRST && nv <= TLAST && nh == TDP) begin
                e_dp = 1; m_line = 1; m_armed = 0; m_kill_sent = 0;
            end
            if (k % (TL * TF) == 0 && !m_zone && !m_line) m_armed = 0;
            if ((zd || dd) && dl) m_nmi = TNMI;
            else if (m_nmi > 0) m_nmi--;
            if (e_zp || (e_dp && !hold_dp)) begin
                if (rnd_mode) lat = $urandom_range(0, 60);
                resp_kind = e_zp ? 1 : 2;
                resp_dli  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                resp_cnt  = lat + 1;
            end
        end
        #1;
        cnt_zp += int'(dma_if.zp_dma_start);
        cnt_dp += int'(dma_if.dp_dma_start);
        act = {7'd0, hcount, vcount, vblank, last_line, dma_if.zp_dma_start,
               dma_if.dp_dma_start, dma_if.dp_dma_kill, halt, nmi};
        exp = {7'd0, 9'(cur_h()), 9'(cur_v()),
               1'(cur_v() < TFIRST || cur_v() > TLAST), 1'(cur_v() == TLAST),
               e_zp, e_dp, e_kill, 1'(m_zone || m_line), 1'(m_nmi > 0)};
        check("cycle", act, exp);
    endtask

    task automatic run_until(input int v, input int h);
        int n = 0;
        while (!(cur_v() == v && cur_h() == h)) begin
            step();
            n++;
            if (n > 3 * TL * TF) begin
                vectors++;
                miscompares++;
                $display("FAIL run_until: position v=%0d h=%0d not reached", v, h);
                return;
            end
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{TFIRST - 1, TZP - 1, 1'b1, 5'b00010};
        tbl[1] = '{TFIRST - 1, TZP,     1'b1, 5'b10110};
        tbl[2] = '{TFIRST - 1, TZP + 1, 1'b1, 5'b00110};
        tbl[3] = '{TFIRST - 1, TZP + 2, 1'b1, 5'b00010};
        tbl[4] = '{TFIRST,     0,       1'b1, 5'b00000};
        tbl[5] = '{TFIRST,     TDP,     1'b1, 5'b01100};
        tbl[6] = '{TFIRST,     TDP + 2, 1'b1, 5'b00000};
        tbl[7] = '{TLAST,      TDP,     1'b1, 5'b01101};
        tbl[8] = '{TLAST + 1,  TDP,     1'b1, 5'b00010};
        tbl[9] = '{TF - 1,     TL - 1,  1'b1, 5'b00010};

        // reset state
        reset = 1'b1;
        step();
        step();
        check("reset hcount", 32'(hcount), 32'd0);
        check("reset vcount", 32'(vcount), 32'd0);
        check("reset outputs", 32'({dma_if.zp_dma_start, dma_if.dp_dma_start,
              dma_if.dp_dma_kill, halt, nmi, vblank, last_line}), 32'b0000010);
        reset = 1'b0;

        // first frame against fixed milestones
        cnt_zp = 0; cnt_dp = 0;
        for (int i = 0; i < 10; i++) begin
            dma_en = tbl[i].en;
            run_until(tbl[i].v, tbl[i].h);
            check($sformatf("table[%0d]", i),
                  32'({dma_if.zp_dma_start, dma_if.dp_dma_start, halt, vblank, last_line}),
                  32'(tbl[i].exp));
        end
        check("zp starts per frame", 32'(cnt_zp), 32'd1);
        check("dp starts per frame", 32'(cnt_dp), 32'(TLAST - TFIRST + 1));

        // overrunning fetch is killed, late done re-arms
        run_until(10, TDP - 1);
        hold_dp = 1;
        run_until(10, TKILL);
        check("kill pulse", 32'(dma_if.dp_dma_kill), 32'd1);
        step();
        check("kill single", 32'(dma_if.dp_dma_kill), 32'd0);
        step();
        man_dp = 1;
        step();
        check("halt after late done", 32'(halt), 32'd0);
        hold_dp = 0;
        run_until(11, TDP);
        check("line after kill starts", 32'(dma_if.dp_dma_start), 32'd1);

        // done on the kill edge wins
        run_until(12, TDP - 1);
        hold_dp = 1;
        run_until(12, TKILL - 1);
        check("halt before coincide", 32'(halt), 32'd1);
        man_dp = 1;
        step();
        check("coincide no kill", 32'(dma_if.dp_dma_kill), 32'd0);
        check("coincide halt drop", 32'(halt), 32'd0);
        hold_dp = 0;

        // single DLI pulse width
        run_until(14, TDP - 1);
        hold_dp = 1;
        run_until(14, TDP + 3);
        check("nmi quiet", 32'(nmi), 32'd0);
        man_dp = 1; man_dli = 1;
        step();
        check("nmi one cycle later", 32'(nmi), 32'd1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            n += int'(nmi);
            step();
        end
        check("nmi width", 32'(n), 32'(TNMI));
        hold_dp = 0;

        // retriggered DLI extends the pulse
        run_until(16, TDP - 1);
        hold_dp = 1;
        run_until(16, TDP + 3);
        man_dp = 1; man_dli = 1;
        step();
        n = 0;
        for (int i = 1; i <= 24; i++) begin
            n += int'(nmi);
            if (i == 3) begin
                man_dp = 1; man_dli = 1;
            end
            step();
        end
        check("nmi retrigger width", 32'(n), 32'(TNMI + 3));
        hold_dp = 0;

        // dma_en dropped mid-fetch
        run_until(18, TDP - 1);
        hold_dp = 1;
        run_until(18, TDP + 12);
        dma_en = 1'b0;
        run_until(18, TDP + 20);
        check("fetch continues", 32'(halt), 32'd1);
        man_dp = 1;
        step();
        check("fetch completes", 32'(halt), 32'd0);
        hold_dp = 0;
        run_until(19, TDP);
        check("disabled line skipped", 32'(dma_if.dp_dma_start), 32'd0);
        run_until(19, TDP + 2);
        dma_en = 1'b1;
        run_until(20, TDP);
        check("re-enable resumes", 32'(dma_if.dp_dma_start), 32'd1);

        // reset in the middle of a line fetch
        run_until(30, TDP - 1);
        hold_dp = 1;
        run_until(30, TDP + 5);
        check("busy before reset", 32'(halt), 32'd1);
        reset = 1'b1;
        step();
        check("mid reset hv", 32'({hcount, vcount}), 32'd0);
        check("mid reset outputs", 32'({dma_if.zp_dma_start, dma_if.dp_dma_start,
              dma_if.dp_dma_kill, halt, nmi, vblank, last_line}), 32'b0000010);
        reset = 1'b0;
        hold_dp = 0;
        cnt_zp = 0;
        run_until(TFIRST - 1, TZP);
        check("zp after reset", 32'(dma_if.zp_dma_start), 32'd1);
        check("zp count after reset", 32'(cnt_zp), 32'd1);

        // randomized enables, latencies, DLIs and stray done pulses
        rnd_mode = 1;
        for (int i = 0; i < 2 * TL * TF; i++) begin
            if ($urandom_range(0, 99) == 0) dma_en = ~dma_en;
            if ($urandom_range(0, 199) == 0) begin
                man_dp  = 1;
                man_dli = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) man_zp = 1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
